// File: rtl/prgm_loader_if.sv
// Byte stream from a program source into the loader.
// The source drives valid/data/last and the loader answers with ready.
interface prgm_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prgm_loader.sv
// Program loader: erases the program memory once, then takes bytes from a
// source one at a time and writes each to consecutive addresses. Every write
// holds address, data and mode steady for WRITE_CYCLES clocks. A session ends
// on a byte flagged last, or when the final memory location has been written.
module prgm_loader #(
  parameter int DEPTH        = 64,
  parameter int WRITE_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  prgm_loader_if.slave                 src,
  output logic [$clog2(DEPTH)-1:0]     mem_adrs,
  output logic                         mem_erase,
  output logic                         mem_mode,
  output logic [7:0]                   mem_data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WCW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ERASE, RECV, WRITE, DONE} state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           last_q;

  // Session sequencer; every output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      last_q       <= 1'b0;
      src.in_ready <= 1'b0;
      mem_adrs     <= '0;
      mem_erase    <= 1'b0;
      mem_mode     <= 1'b0;
      mem_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ERASE;
            count     <= '0;
            mem_adrs  <= '0;
            mem_erase <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ERASE: begin
          mem_erase    <= 1'b0;
          src.in_ready <= 1'b1;
          state        <= RECV;
        end
        RECV: begin
          if (src.in_valid) begin
            mem_data     <= src.in_data;
            last_q       <= src.in_last;
            src.in_ready <= 1'b0;
            mem_mode     <= 1'b1;
            wcnt         <= '0;
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (wcnt == WCW'(WRITE_CYCLES - 1)) begin
            mem_mode <= 1'b0;
            count    <= count + CW'(1);
            if (last_q || (mem_adrs == AW'(DEPTH - 1))) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              mem_adrs     <= mem_adrs + AW'(1);
              src.in_ready <= 1'b1;
              state        <= RECV;
            end
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prgm_loader.sv
// Directed bench for prgm_loader with a behavioural program memory attached
// to the write port so loaded contents can be read back.
module tb_prgm_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] mem_adrs;
  logic       mem_erase;
  logic       mem_mode;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic [6:0] count;

  int total = 0;
  int bad   = 0;
  int overlap_errs = 0;

  logic [7:0] mem [64];

  prgm_loader_if src ();

  prgm_loader #(.DEPTH(64), .WRITE_CYCLES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src       (src.slave),
    .mem_adrs  (mem_adrs),
    .mem_erase (mem_erase),
    .mem_mode  (mem_mode),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Program memory model: erase clears every byte, mode=1 writes the byte.
  always @(posedge clk) begin
    if (mem_erase) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_mode) begin
      mem[mem_adrs] <= mem_data;
    end
    if (mem_erase && mem_mode) overlap_errs <= overlap_errs + 1;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [7:0] d, input logic l);
    reset        = r;
    start        = s;
    src.in_valid = v;
    src.in_data  = d;
    src.in_last  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hands one byte over from RECV and checks the three write cycles that follow.
  // With hold set, valid stays high and the source data changes during WRITE.
  task automatic doByte(input logic [7:0] d, input logic l, input int adrs,
                        input bit hold);
    checkOutput("ready_in_recv", 32'(src.in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, d, l);
    step();
    applyStimulus(1'b0, 1'b0, hold, hold ? ~d : 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("write_mode",  32'(mem_mode), 32'd1);
      checkOutput("write_adrs",  32'(mem_adrs), 32'(adrs));
      checkOutput("write_data",  32'(mem_data), 32'(d));
      checkOutput("write_ready", 32'(src.in_ready), 32'd0);
      checkOutput("write_erase", 32'(mem_erase), 32'd0);
      step();
    end
  endtask

  // Directed sequence covering reset, normal load, full-depth load,
  // reset during a write, and ignored start pulses.
  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_ready", 32'(src.in_ready), 32'd0);
    checkOutput("rst_adrs",  32'(mem_adrs), 32'd0);
    checkOutput("rst_erase", 32'(mem_erase), 32'd0);
    checkOutput("rst_mode",  32'(mem_mode), 32'd0);
    checkOutput("rst_data",  32'(mem_data), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_done",  32'(done), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);

    // Three-byte program ending on in_last.
    $display("[TB] three byte load");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("erase_on",    32'(mem_erase), 32'd1);
    checkOutput("erase_busy",  32'(busy), 32'd1);
    checkOutput("erase_mode",  32'(mem_mode), 32'd0);
    checkOutput("erase_ready", 32'(src.in_ready), 32'd0);
    step();
    checkOutput("erase_off",   32'(mem_erase), 32'd0);
    checkOutput("recv_busy",   32'(busy), 32'd1);
    doByte(8'h11, 1'b0, 0, 1'b0);
    checkOutput("b1_count", 32'(count), 32'd1);
    checkOutput("b1_adrs",  32'(mem_adrs), 32'd1);
    doByte(8'h22, 1'b0, 1, 1'b0);
    doByte(8'h33, 1'b1, 2, 1'b0);
    checkOutput("t1_done",  32'(done), 32'd1);
    checkOutput("t1_busy",  32'(busy), 32'd0);
    checkOutput("t1_count", 32'(count), 32'd3);
    checkOutput("t1_mode",  32'(mem_mode), 32'd0);
    checkOutput("t1_ready", 32'(src.in_ready), 32'd0);
    step();
    checkOutput("t1_done_pulse", 32'(done), 32'd0);
    checkOutput("t1_count_hold", 32'(count), 32'd3);
    checkOutput("t1_mem0", 32'(mem[0]), 32'h11);
    checkOutput("t1_mem2", 32'(mem[2]), 32'h33);

    // Full 64-byte program without in_last, valid held high throughout.
    $display("[TB] full depth load");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 64; i++) begin
      doByte(8'(i * 3 + 1), 1'b0, i, 1'b1);
      if (i < 63) checkOutput("full_count", 32'(count), 32'(i + 1));
    end
    checkOutput("full_done",  32'(done), 32'd1);
    checkOutput("full_count", 32'(count), 32'd64);
    checkOutput("full_adrs",  32'(mem_adrs), 32'd63);
    checkOutput("full_busy",  32'(busy), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("after_ready", 32'(src.in_ready), 32'd0);
      checkOutput("after_mode",  32'(mem_mode), 32'd0);
      step();
    end
    checkOutput("full_mem2",  32'(mem[2]), 32'h07);
    checkOutput("full_mem63", 32'(mem[63]), 32'hBE);
    checkOutput("full_count_hold", 32'(count), 32'd64);

    // Reset in the second write cycle of the fifth byte.
    $display("[TB] reset during write");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 4; i++) doByte(8'(8'h40 + i), 1'b0, i, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("b5_mode", 32'(mem_mode), 32'd1);
    checkOutput("b5_adrs", 32'(mem_adrs), 32'd4);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rw_mode",  32'(mem_mode), 32'd0);
    checkOutput("rw_busy",  32'(busy), 32'd0);
    checkOutput("rw_count", 32'(count), 32'd0);
    checkOutput("rw_adrs",  32'(mem_adrs), 32'd0);
    checkOutput("rw_ready", 32'(src.in_ready), 32'd0);
    checkOutput("rw_erase", 32'(mem_erase), 32'd0);
    step();
    checkOutput("rw_mode_idle", 32'(mem_mode), 32'd0);

    // Start pulses in RECV and DONE must not disturb the session.
    $display("[TB] ignored start pulses");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("recv_start_erase", 32'(mem_erase), 32'd0);
    checkOutput("recv_start_adrs",  32'(mem_adrs), 32'd0);
    doByte(8'hA5, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("recv2_erase", 32'(mem_erase), 32'd0);
    checkOutput("recv2_adrs",  32'(mem_adrs), 32'd1);
    checkOutput("recv2_count", 32'(count), 32'd1);
    doByte(8'h5A, 1'b1, 1, 1'b0);
    checkOutput("t4_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("done_start_busy",  32'(busy), 32'd0);
    checkOutput("done_start_erase", 32'(mem_erase), 32'd0);
    checkOutput("done_start_count", 32'(count), 32'd2);
    step();
    checkOutput("idle_busy",  32'(busy), 32'd0);
    checkOutput("idle_erase", 32'(mem_erase), 32'd0);
    checkOutput("rd_adrs0", 32'(mem[0]), 32'hA5);
    checkOutput("rd_adrs1", 32'(mem[1]), 32'h5A);
    checkOutput("rd_adrs2", 32'(mem[2]), 32'h00);
    checkOutput("erase_mode_overlap", 32'(overlap_errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
